// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate front end: weight RAM, 4-stage MAC pipeline,
// saturating accumulate and bias add producing a one-cycle sum pulse.
module neuron_mac #(
    parameter int dataWidth    = 16,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      weightValid,
    input  logic [addressWidth-1:0]   weightAddr,
    input  logic [dataWidth-1:0]      weightValue,
    input  logic                      biasValid,
    input  logic [2*dataWidth-1:0]    biasValue,
    input  logic [dataWidth-1:0]      myinput,
    input  logic                      myinputValid,
    output logic [2*dataWidth-1:0]    sum,
    output logic                      sumValid
);

    localparam int SW = 2 * dataWidth;
    localparam int DEPTH = 2 ** addressWidth;
    localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a,
                                              input logic [SW-1:0] b);
        logic [SW-1:0] s;
        s = a + b;
        if (a[SW-1] == b[SW-1] && s[SW-1] != a[SW-1]) begin
            s = a[SW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        end
        return s;
    endfunction

    logic [dataWidth-1:0]    mem_q [DEPTH];
    logic [dataWidth-1:0]    w_q;
    logic [addressWidth-1:0] r_addr_q, r_addr_d;
    logic [dataWidth-1:0]    x_q, x_d;
    logic                    v0_q, v0_d, first0_q, first0_d, last0_q, last0_d;
    logic [SW-1:0]           mul_q, mul_d;
    logic                    v1_q, v1_d, first1_q, first1_d, last1_q, last1_d;
    logic [SW-1:0]           acc_q, acc_d;
    logic                    v2_q, v2_d, last2_q, last2_d;
    logic [SW-1:0]           bias_q, bias_d;
    logic [SW-1:0]           sum_q, sum_d;
    logic                    sum_valid_q, sum_valid_d;

    // Read-first RAM: a same-cycle write to the read address returns old data.
    always_ff @(posedge clk) begin
        if (weightValid) begin
            mem_q[weightAddr] <= weightValue;
        end
        if (myinputValid) begin
            w_q <= mem_q[r_addr_q];
        end
    end

    always_comb begin
        r_addr_d = r_addr_q;
        if (myinputValid) begin
            r_addr_d = (r_addr_q == LAST_ADDR) ? '0 : r_addr_q + 1'b1;
        end
        v0_d     = myinputValid;
        x_d      = myinputValid ? myinput : x_q;
        first0_d = myinputValid ? (r_addr_q == '0) : first0_q;
        last0_d  = myinputValid ? (r_addr_q == LAST_ADDR) : last0_q;

        v1_d     = v0_q;
        mul_d    = v0_q ? SW'($signed(x_q)) * SW'($signed(w_q)) : mul_q;
        first1_d = v0_q ? first0_q : first1_q;
        last1_d  = v0_q ? last0_q : last1_q;

        v2_d     = v1_q;
        acc_d    = acc_q;
        if (v1_q) begin
            acc_d = first1_q ? mul_q : sat_add(acc_q, mul_q);
        end
        last2_d  = v1_q ? last1_q : last2_q;

        sum_valid_d = v2_q && last2_q;
        sum_d       = sum_valid_d ? sat_add(acc_q, bias_q) : sum_q;
        bias_d      = biasValid ? biasValue : bias_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_q    <= '0;
            x_q         <= '0;
            v0_q        <= 1'b0;
            first0_q    <= 1'b0;
            last0_q     <= 1'b0;
            mul_q       <= '0;
            v1_q        <= 1'b0;
            first1_q    <= 1'b0;
            last1_q     <= 1'b0;
            acc_q       <= '0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            bias_q      <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            r_addr_q    <= r_addr_d;
            x_q         <= x_d;
            v0_q        <= v0_d;
            first0_q    <= first0_d;
            last0_q     <= last0_d;
            mul_q       <= mul_d;
            v1_q        <= v1_d;
            first1_q    <= first1_d;
            last1_q     <= last1_d;
            acc_q       <= acc_d;
            v2_q        <= v2_d;
            last2_q     <= last2_d;
            bias_q      <= bias_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum      = sum_q;
    assign sumValid = sum_valid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized self-checking bench for neuron_mac (numWeight=4 and numWeight=1).
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wvalid = 1'b0;
    logic [9:0]  wa = '0;
    logic [15:0] wv = '0;
    logic        bvalid = 1'b0;
    logic [31:0] bv = '0;
    logic [15:0] mi = '0;
    logic        miv = 1'b0;
    logic [31:0] sum4, sum1;
    logic        sv4, sv1;

    always #5 clk = ~clk;

    neuron_mac #(.dataWidth(16), .numWeight(4), .addressWidth(3)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .weightValid(wvalid), .weightAddr(wa[2:0]), .weightValue(wv),
        .biasValid(bvalid), .biasValue(bv),
        .myinput(mi), .myinputValid(miv),
        .sum(sum4), .sumValid(sv4)
    );

    neuron_mac #(.dataWidth(16), .numWeight(1), .addressWidth(10)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .weightValid(wvalid), .weightAddr(wa), .weightValue(wv),
        .biasValid(bvalid), .biasValue(bv),
        .myinput(mi), .myinputValid(miv),
        .sum(sum1), .sumValid(sv1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] q4[$];
    int          t4[$];
    logic [31:0] q1[$];

    always @(negedge clk) begin
        if (sv4 === 1'b1) begin
            q4.push_back(sum4);
            t4.push_back(cyc);
        end
        if (sv1 === 1'b1) q1.push_back(sum1);
    end

    int n_tests = 0;
    int n_fail = 0;
    logic signed [15:0] wref[4];
    logic signed [15:0] xv[8];
    logic [31:0] bref = '0;
    int last_edge = 0;

    function automatic logic [31:0] clamp(input longint v);
        longint lim;
        lim = 64'sd2147483647;
        if (v > lim) return 32'h7FFFFFFF;
        if (v < -lim - 1) return 32'h80000000;
        return 32'(v);
    endfunction

    // Dot product of xv[base..base+3] with wref, clamped after every add.
    function automatic logic [31:0] model(input int base);
        longint acc;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            acc = longint'($signed(clamp(acc + longint'(xv[base+i]) * longint'(wref[i]))));
        end
        return clamp(acc + longint'($signed(bref)));
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_w(input int a, input logic [15:0] v);
        wa = 10'(a);
        wv = v;
        wvalid = 1'b1;
        idle(1);
        wvalid = 1'b0;
        if (a < 4) wref[a] = v;
    endtask

    task automatic wr_b(input logic [31:0] v);
        bv = v;
        bvalid = 1'b1;
        idle(1);
        bvalid = 1'b0;
        bref = v;
    endtask

    task automatic send(input logic [15:0] x, input int gap);
        mi = x;
        miv = 1'b1;
        idle(1);
        last_edge = cyc;
        miv = 1'b0;
        idle(gap);
    endtask

    task automatic send_vec(input int base, input int gapmax);
        for (int i = 0; i < 4; i++) begin
            send(xv[base+i], gapmax == 0 ? 0 : int'($urandom_range(1, gapmax)));
        end
    endtask

    task automatic set_w1234();
        for (int i = 0; i < 4; i++) wr_w(i, 16'(i + 1));
    endtask

    task automatic load_5678();
        xv[0] = 16'sd5; xv[1] = 16'sd6; xv[2] = 16'sd7; xv[3] = 16'sd8;
    endtask

    task automatic check_one(input string name, input logic [31:0] exp);
        n_tests++;
        if (q4.size() !== 1) begin
            n_fail++;
            $display("FAIL %s_count: got %0d pulses want 1", name, q4.size());
        end else if (q4[0] !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, q4[0], exp);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        idle(2);
        n_tests++;
        if (sv4 !== 1'b0 || sum4 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset4: got sv=%b sum=%h want 0/0", sv4, sum4);
        end
        n_tests++;
        if (sv1 !== 1'b0 || sum1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset1: got sv=%b sum=%h want 0/0", sv1, sum1);
        end
        rst_n = 1'b1;
        bref = '0;
        idle(2);
        n_tests++;
        if (sv4 !== 1'b0 || sum4 !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset: got sv=%b sum=%h want 0/0", sv4, sum4);
        end
    endtask

    task automatic test_basic();
        set_w1234();
        wr_b(32'd10);
        load_5678();
        q4.delete(); t4.delete();
        send_vec(0, 0);
        idle(6);
        check_one("basic", 32'd80);
        n_tests++;
        if (t4.size() != 1 || t4[0] - last_edge != 3) begin
            n_fail++;
            $display("FAIL latency: got %0d want 3",
                     t4.size() == 1 ? t4[0] - last_edge : -1);
        end
        n_tests++;
        if (sum4 !== 32'd80 || sv4 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got sv=%b sum=%h want 0/00000050", sv4, sum4);
        end
    endtask

    task automatic test_sat(input string name, input logic [15:0] w,
                            input logic [15:0] x, input logic [31:0] b,
                            input logic [31:0] exp);
        for (int i = 0; i < 4; i++) wr_w(i, w);
        wr_b(b);
        for (int i = 0; i < 4; i++) xv[i] = x;
        q4.delete(); t4.delete();
        send_vec(0, 0);
        idle(6);
        check_one(name, exp);
    endtask

    task automatic test_back_to_back();
        set_w1234();
        wr_b(32'd10);
        load_5678();
        for (int i = 4; i < 8; i++) xv[i] = 16'sd1;
        q4.delete(); t4.delete();
        send_vec(0, 0);
        send_vec(4, 0);
        idle(6);
        n_tests++;
        if (q4.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses want 2", q4.size());
        end else begin
            n_tests++;
            if (q4[0] !== 32'd80) begin
                n_fail++;
                $display("FAIL b2b_first: got %h want %h", q4[0], 32'd80);
            end
            n_tests++;
            if (q4[1] !== 32'd20) begin
                n_fail++;
                $display("FAIL b2b_second: got %h want %h", q4[1], 32'd20);
            end
            n_tests++;
            if (t4[1] - t4[0] != 4) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d want 4", t4[1] - t4[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_w1234();
        wr_b(32'd10);
        q4.delete(); t4.delete();
        send(16'd5, 0);
        send(16'd6, 0);
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (sv4 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_valid: got %b want 0", sv4);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bref = '0;
        idle(5);
        n_tests++;
        if (q4.size() != 0) begin
            n_fail++;
            $display("FAIL mid_reset_pulse: got %0d pulses want 0", q4.size());
        end
        wr_b(32'd10);
        load_5678();
        q4.delete(); t4.delete();
        send_vec(0, 0);
        idle(6);
        check_one("after_reset", 32'd80);
    endtask

    task automatic test_random();
        logic [15:0] ext[2];
        ext[0] = 16'h7FFF;
        ext[1] = 16'h8000;
        for (int v = 0; v < 20; v++) begin
            for (int i = 0; i < 4; i++) begin
                wr_w(i, (v % 4 == 3) ? ext[$urandom_range(0, 1)] : 16'($urandom));
            end
            if (v % 5 == 4) wr_b($urandom_range(0, 1) ? 32'h7FFFFF00 : 32'h80000100);
            else wr_b(32'($signed(16'($urandom))));
            for (int i = 0; i < 4; i++) begin
                xv[i] = (v % 4 == 3) ? ext[$urandom_range(0, 1)] : 16'($urandom);
            end
            q4.delete(); t4.delete();
            send_vec(0, 5);
            idle(6);
            check_one("random", model(0));
        end
    endtask

    task automatic test_single();
        logic [15:0] x;
        logic [31:0] exp;
        for (int k = 0; k < 8; k++) begin
            wr_w(0, 16'($urandom));
            wr_b((k == 7) ? 32'h7FFFFFFF : 32'($urandom));
            x = (k == 7) ? 16'h7FFF : 16'($urandom);
            if (k == 7) wr_w(0, 16'h7FFF);
            exp = clamp(longint'($signed(x)) * longint'(wref[0]) + longint'($signed(bref)));
            q1.delete();
            send(x, 0);
            idle(5);
            n_tests++;
            if (q1.size() != 1) begin
                n_fail++;
                $display("FAIL single_count: got %0d pulses want 1", q1.size());
            end else if (q1[0] !== exp) begin
                n_fail++;
                $display("FAIL single: got %h want %h", q1[0], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat("pos_sat", 16'h7FFF, 16'h7FFF, 32'h0, 32'h7FFFFFFF);
        test_sat("neg_sat", 16'h8000, 16'h7FFF, 32'hFFFFFFFF, 32'h80000000);
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_single();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
